// File: rtl/pq_stream_sorter.sv
// ---------------------------------------------------------------------------
// pq_stream_sorter
//
// Sorts a batch of upstream items into ascending order using an external
// priority queue. Items are inserted into the queue while in FILL; once the
// batch ends (explicit s_last or the queue becoming full) the block switches
// to DRAIN, pops the queue head one item at a time and streams the results
// downstream through a 2-entry output FIFO.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RSTn       synchronous active-low reset
//   s_valid    upstream item valid
//   s_ready    upstream item accepted when s_valid && s_ready
//   s_data     upstream item
//   s_last     final item of the current batch
//   m_valid    sorted item valid (output FIFO non-empty)
//   m_ready    downstream accept
//   m_data     sorted item, ascending within a batch
//   m_last     final sorted item of the batch
//   pq_valid   priority queue request strobe
//   pq_write   1 = insert, 0 = pop
//   pq_data    insert data
//   pq_rvalid  pop response valid, one cycle after the pop request
//   pq_rdata   queue head value returned for the pop
//   err        sticky protocol error (cleared only by reset)
// ---------------------------------------------------------------------------
module pq_stream_sorter #(
  parameter int QUEUE_DETH  = 32,
  parameter int DATA_LENGTH = 32
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_LENGTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_LENGTH-1:0] m_data,
  output logic                   m_last,
  output logic                   pq_valid,
  output logic                   pq_write,
  output logic [DATA_LENGTH-1:0] pq_data,
  input  logic                   pq_rvalid,
  input  logic [DATA_LENGTH-1:0] pq_rdata,
  output logic                   err
);

  localparam int            CW    = $clog2(QUEUE_DETH) + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DETH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Items currently held in the attached queue, items inserted for this
  // batch, and pops issued so far while draining it.
  logic [CW-1:0] count;
  logic [CW-1:0] batch_size;
  logic [CW-1:0] issued;

  // One pop may be outstanding; its response lands in the FIFO next cycle.
  logic inflight;
  logic inflight_last;

  // Two-entry output FIFO.
  logic [DATA_LENGTH-1:0] fifo_data [2];
  logic [1:0]             fifo_last;
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             occ;

  logic       accept;
  logic       pop;
  logic       final_pop;
  logic       deq;
  logic       last_out;
  logic [1:0] occ_after;

  // The FIFO head drives the downstream port directly, so data and last
  // stay stable for as long as the consumer stalls.
  assign m_valid  = (occ != 2'd0);
  assign m_data   = fifo_data[rd_ptr];
  assign m_last   = m_valid & fifo_last[rd_ptr];
  assign deq      = m_valid & m_ready;
  assign last_out = deq & m_last;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a batch ends on an explicit last beat or when the
  // accepted beat fills the queue; draining ends when the last sorted item
  // leaves the block.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (accept && (s_last || (count == DEPTH - ONE))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_out) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Output / request logic. A pop is allowed only if the FIFO, after this
  // cycle's dequeue, still has room for both the response already in
  // flight and the new one. Pops are suppressed while reset is asserted so
  // no response can arrive after the queue and this block come out of reset.
  always_comb begin
    s_ready   = 1'b0;
    pop       = 1'b0;
    final_pop = 1'b0;
    occ_after = occ - {1'b0, deq} + {1'b0, inflight};
    if (state == FILL) begin
      s_ready = (count < DEPTH);
    end else if (RSTn && (issued < batch_size) && (occ_after < 2'd2)) begin
      pop = 1'b1;
    end
    if (pop && (issued == batch_size - ONE)) begin
      final_pop = 1'b1;
    end
    accept   = s_valid & s_ready;
    pq_valid = accept | pop;
    pq_write = accept;
    pq_data  = s_data;
  end

  // Batch bookkeeping. Everything clears together when the final sorted
  // item is accepted, so the next FILL starts from an empty queue.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      count      <= '0;
      batch_size <= '0;
      issued     <= '0;
    end else if ((state == DRAIN) && last_out) begin
      count      <= '0;
      batch_size <= '0;
      issued     <= '0;
    end else begin
      if (accept && (count < DEPTH)) begin
        count      <= count + ONE;
        batch_size <= batch_size + ONE;
      end
      if (pop) begin
        if (count != '0) begin
          count <= count - ONE;
        end
        issued <= issued + ONE;
      end
    end
  end

  // Pop tracking and protocol checking. A response with nothing pending, or
  // a missing response after a pop, sets the sticky error flag.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err           <= 1'b0;
    end else begin
      inflight      <= pop;
      inflight_last <= final_pop;
      if ((pq_rvalid && !inflight) || (inflight && !pq_rvalid)) begin
        err <= 1'b1;
      end
    end
  end

  // Output FIFO. The slot reserved by a pop is always filled one cycle
  // later, even if the response strobe went missing; that keeps the drain
  // moving after an error at the cost of undefined data in that slot.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      occ          <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= pq_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, deq};
    end
  end

endmodule

// File: tb/tb_pq_stream_sorter.sv
// ---------------------------------------------------------------------------
// tb_pq_stream_sorter
//
// Drives batches into pq_stream_sorter with a behavioural priority queue
// attached, and compares every sorted output beat against a reference built
// by splitting the input stream into batches and sorting each one.
// ---------------------------------------------------------------------------
module tb_pq_stream_sorter;

  localparam int QD = 8;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          pq_valid;
  logic          pq_write;
  logic [DW-1:0] pq_data;
  logic          pq_rvalid;
  logic [DW-1:0] pq_rdata;
  logic          err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_no     = 0;

  // Reference state: what the block should be doing according to the rules.
  bit fill_m  = 1'b1;
  int held_m  = 0;
  bit exp_err = 1'b0;

  logic [DW-1:0] in_data [$];
  bit            in_last [$];
  logic [DW-1:0] exp_data [$];
  bit            exp_last [$];
  int            out_cycles [$];
  int            last_in_cycle;

  // Attached priority queue model.
  logic [DW-1:0] pq_model [$];
  logic          env_rvalid = 1'b0;
  logic [DW-1:0] env_rdata  = '0;
  logic          inject     = 1'b0;
  logic          req_v      = 1'b0;
  logic          req_w      = 1'b0;
  logic [DW-1:0] req_d      = '0;
  logic          rst_l      = 1'b0;

  assign pq_rvalid = env_rvalid | inject;
  assign pq_rdata  = env_rdata;

  pq_stream_sorter #(
    .QUEUE_DETH (QD),
    .DATA_LENGTH(DW)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .pq_valid (pq_valid),
    .pq_write (pq_write),
    .pq_data  (pq_data),
    .pq_rvalid(pq_rvalid),
    .pq_rdata (pq_rdata),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle_no <= cycle_no + 1;

  // Capture the queue request mid-cycle, then act on it just after the edge.
  always @(negedge CLK) begin
    req_v = pq_valid;
    req_w = pq_write;
    req_d = pq_data;
    rst_l = RSTn;
  end

  always @(posedge CLK) begin
    int mi;
    #1;
    env_rvalid = 1'b0;
    if (!rst_l) begin
      pq_model.delete();
    end else if (req_v && req_w) begin
      pq_model.push_back(req_d);
    end else if (req_v && !req_w) begin
      env_rvalid = 1'b1;
      env_rdata  = '0;
      if (pq_model.size() > 0) begin
        mi = 0;
        for (int i = 1; i < pq_model.size(); i++) begin
          if (pq_model[i] < pq_model[mi]) mi = i;
        end
        env_rdata = pq_model[mi];
        pq_model.delete(mi);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RSTn    = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    inject  = 1'b0;
    tick();
    RSTn    = 1'b1;
    fill_m  = 1'b1;
    held_m  = 0;
    exp_err = 1'b0;
  endtask

  // Split the input stream into batches (explicit last or QD items) and
  // sort each batch to form the expected output stream.
  function automatic void build_expected();
    logic [DW-1:0] batch [$];
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < in_data.size(); i++) begin
      batch.push_back(in_data[i]);
      if (in_last[i] || batch.size() == QD) begin
        batch.sort();
        for (int j = 0; j < batch.size(); j++) begin
          exp_data.push_back(batch[j]);
          exp_last.push_back(j == batch.size() - 1);
        end
        batch.delete();
      end
    end
  endfunction

  // ready_mode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  task automatic run_traffic(input int stop_after, input int ready_mode);
    int            idx;
    int            outs;
    int            cyc;
    int            pops;
    int            max_out;
    bit            stalled;
    logic [DW-1:0] held_data;
    logic          held_last;
    idx = 0; outs = 0; cyc = 0; pops = 0; max_out = 0; stalled = 1'b0;
    held_data = '0; held_last = 1'b0;
    out_cycles.delete();
    last_in_cycle = -1;
    while (outs < stop_after && cyc < 4000) begin
      tick();
      if (idx < in_data.size()) begin
        s_valid = 1'b1;
        s_data  = in_data[idx];
        s_last  = in_last[idx];
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
      end
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge CLK);
      tests_run++;
      if (s_ready !== (fill_m && held_m < QD)) begin
        tests_failed++;
        $display("[TB] FAIL s_ready: got %b expected %b (cycle %0d)", s_ready, (fill_m && held_m < QD), cycle_no);
      end
      if (stalled) begin
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last) begin
          tests_failed++;
          $display("[TB] FAIL stall_hold: got v=%b d=%0h l=%b expected v=1 d=%0h l=%b", m_valid, m_data, m_last, held_data, held_last);
        end
      end
      if (pq_valid === 1'b1 && pq_write === 1'b0) pops++;
      if (s_valid && s_ready === 1'b1) begin
        idx++;
        held_m++;
        last_in_cycle = cycle_no;
        if (s_last || held_m == QD) fill_m = 1'b0;
      end
      if (m_valid === 1'b1 && m_ready) begin
        tests_run++;
        if (outs >= exp_data.size()) begin
          tests_failed++;
          $display("[TB] FAIL extra_output: got d=%0h with no item expected", m_data);
        end else begin
          if (m_data !== exp_data[outs] || m_last !== exp_last[outs]) begin
            tests_failed++;
            $display("[TB] FAIL out_beat[%0d]: got d=%0h l=%b expected d=%0h l=%b", outs, m_data, m_last, exp_data[outs], exp_last[outs]);
          end
          if (exp_last[outs]) begin
            fill_m = 1'b1;
            held_m = 0;
          end
        end
        out_cycles.push_back(cycle_no);
        outs++;
      end
      if (pops - outs > max_out) max_out = pops - outs;
      stalled   = (m_valid === 1'b1) && !m_ready;
      held_data = m_data;
      held_last = m_last;
      cyc++;
    end
    tests_run++;
    if (outs < stop_after) begin
      tests_failed++;
      $display("[TB] FAIL timeout: got %0d outputs expected %0d", outs, stop_after);
    end
    tests_run++;
    if (max_out > 2) begin
      tests_failed++;
      $display("[TB] FAIL occupancy: got %0d items buffered expected at most 2", max_out);
    end
    if (stop_after == exp_data.size()) begin
      tests_run++;
      if (pops != exp_data.size()) begin
        tests_failed++;
        $display("[TB] FAIL pop_count: got %0d expected %0d", pops, exp_data.size());
      end
    end
    tests_run++;
    if (err !== exp_err) begin
      tests_failed++;
      $display("[TB] FAIL err_flag: got %b expected %b", err, exp_err);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic load_batch(input int n, input int max_val, input bit with_last);
    in_data.delete();
    in_last.delete();
    for (int i = 0; i < n; i++) begin
      in_data.push_back(DW'($urandom_range(0, max_val)));
      in_last.push_back(with_last && (i == n - 1));
    end
  endtask

  task automatic check_latency(input string name);
    tests_run++;
    if (out_cycles.size() == 0 || out_cycles[0] !== last_in_cycle + 3) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: got first output cycle %0d expected %0d", name,
               (out_cycles.size() > 0) ? out_cycles[0] : -1, last_in_cycle + 3);
    end
    for (int i = 1; i < out_cycles.size(); i++) begin
      tests_run++;
      if (out_cycles[i] !== out_cycles[0] + i) begin
        tests_failed++;
        $display("[TB] FAIL %s_throughput[%0d]: got cycle %0d expected %0d", name, i, out_cycles[i], out_cycles[0] + i);
      end
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    tick();
    apply_reset();
    @(negedge CLK);
    tests_run += 7;
    if (s_ready !== 1'b1)  begin tests_failed++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready);   end
    if (m_valid !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid);   end
    if (m_last !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_m_last: got %b expected 0", m_last);     end
    if (pq_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pq_valid: got %b expected 0", pq_valid); end
    if (pq_write !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pq_write: got %b expected 0", pq_write); end
    if (err !== 1'b0)      begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err);           end
    if (m_data !== '0)     begin tests_failed++; $display("[TB] FAIL reset_m_data: got %0h expected 0", m_data);    end
  endtask

  task automatic test_basic_batch();
    in_data = '{DW'(5), DW'(3), DW'(9), DW'(1)};
    in_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    build_expected();
    run_traffic(exp_data.size(), 0);
    check_latency("basic");
    @(negedge CLK);
    tests_run++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_refill: got s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_single_item();
    in_data = '{DW'(7)};
    in_last = '{1'b1};
    build_expected();
    run_traffic(exp_data.size(), 0);
    check_latency("single");
  endtask

  task automatic test_implicit_end();
    load_batch(QD + 2, 65535, 1'b1);
    build_expected();
    run_traffic(exp_data.size(), 2);
  endtask

  task automatic test_stall_pattern();
    load_batch(8, 65535, 1'b1);
    build_expected();
    run_traffic(exp_data.size(), 1);
  endtask

  task automatic test_random_batches();
    int n;
    for (int b = 0; b < 5; b++) begin
      n = $urandom_range(1, QD + 3);
      load_batch(n, (b % 2) ? 15 : 65535, 1'b1);
      build_expected();
      run_traffic(exp_data.size(), 2);
    end
  endtask

  task automatic test_error_injection();
    inject = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_before_inject: got %b expected 0", err);
    end
    tick();
    inject = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_set: got %b expected 1", err);
    end
    repeat (5) tick();
    @(negedge CLK);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: got %b expected 1", err);
    end
    exp_err = 1'b1;
    load_batch(5, 65535, 1'b1);
    build_expected();
    run_traffic(exp_data.size(), 0);
    apply_reset();
    @(negedge CLK);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_cleared: got %b expected 0", err);
    end
  endtask

  task automatic test_reset_mid_drain();
    load_batch(6, 65535, 1'b1);
    build_expected();
    run_traffic(3, 0);
    apply_reset();
    @(negedge CLK);
    tests_run += 4;
    if (m_valid !== 1'b0)  begin tests_failed++; $display("[TB] FAIL mid_reset_m_valid: got %b expected 0", m_valid);   end
    if (s_ready !== 1'b1)  begin tests_failed++; $display("[TB] FAIL mid_reset_s_ready: got %b expected 1", s_ready);   end
    if (err !== 1'b0)      begin tests_failed++; $display("[TB] FAIL mid_reset_err: got %b expected 0", err);           end
    if (pq_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_pq_valid: got %b expected 0", pq_valid); end
    // A full-depth batch without last only ends correctly if count restarted at 0.
    load_batch(QD, 65535, 1'b0);
    build_expected();
    run_traffic(exp_data.size(), 0);
  endtask

  initial begin
    RSTn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_basic_batch();
    test_single_item();
    test_implicit_end();
    test_stall_pattern();
    test_random_batches();
    test_error_injection();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
